atomik_pll_supervisor: RTL
==========================

// Module: atomik_pll_supervisor
// PURPOSE
//  Sequences the 94.5 MHz rPLL: pulses PLL reset, waits for lock with timeout/retry, qualifies lock stability,
//  then releases the design reset request. Runs on the 27 MHz board clock (PLL input), sits between board reset
//  and the PLL wrapper + 94.5 MHz reset synchronizers. Re-sequences on lock loss; latches FAULT after retries exhausted.
// PARAMETERS
//  PLL_RST_CYCLES       27     clkin cycles pll_reset held high per attempt (1 us @ 27 MHz)
//  LOCK_TIMEOUT_CYCLES  27000  clkin cycles allowed in WAIT_LOCK before attempt fails (1 ms)
//  LOCK_STABLE_CYCLES   2048   consecutive synced-lock cycles required before release
//  MAX_RETRIES          3      failed attempts retried before FAULT (0 = first failure faults)
// PORTS
//  clkin            in   1  27 MHz reference clock; only clock of this block
//  reset            in   1  synchronous, active-high
//  restart          in   1  1-cycle pulse: abort current state, clear retries/fault, start new sequence
//  pll_lock         in   1  raw rPLL lock (asynchronous to clkin)
//  pll_reset        out  1  to rPLL RESET
//  rst_out          out  1  design reset request, high until lock qualified
//  ready            out  1  high only in RUN
//  fault            out  1  high only in FAULT
//  state_o          out  3  current state code
//  retry_cnt        out  2  failed attempts in current sequence
//  lock_loss_count  out  8  saturating lock-loss counter (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered. reset: state=PLL_RST, pll_reset=1, rst_out=1, ready=0, fault=0, retry_cnt=0,
//    cycle counter=0, lock_loss_count=0. reset beats restart; restart beats every other event.
//  - pll_lock passes 2-flop sync -> lock_s; 2-cycle latency, counted in all windows below.
//  - PLL_RST(0): pll_reset=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK, counter=0.
//  - WAIT_LOCK(1): pll_reset=0. lock_s=1 -> STABLE, counter=0. Counter hits LOCK_TIMEOUT_CYCLES-1 without
//    lock: retry_cnt==MAX_RETRIES -> FAULT, else retry_cnt+1 -> PLL_RST.
//  - STABLE(2): lock_s=0 any cycle -> WAIT_LOCK, counter=0, no retry consumed (timeout restarts).
//    LOCK_STABLE_CYCLES consecutive lock_s=1 -> RUN; lock drop on the completing cycle wins (-> WAIT_LOCK).
//  - RUN(3): rst_out=0, ready=1 on the first RUN cycle; retry_cnt cleared on entry. lock_s=0 -> rst_out=1,
//    ready=0 next cycle, lock_loss_count+1, -> PLL_RST.
//  - FAULT(4): pll_reset=1, rst_out=1, fault=1; left only by reset or restart.
//  - restart in any state: -> PLL_RST, counter=0, retry_cnt=0, fault=0 next cycle.
//  - Counter width $clog2 of max(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)+1; no wrap.
//  - Codes 5-7 unreachable; decode as PLL_RST.
// CONFIGURATION
//  ATOMIK_PLL_SUP_STATS_EN defined: lock_loss_count counts RUN->PLL_RST lock losses, saturates at 255,
//    cleared only by reset (not restart).
//  Undefined: counter not built, lock_loss_count tied 8'd0.
// STRUCTURE
//  atomik_pll_pkg.vh: state localparams (ST_PLL_RST..ST_FAULT) and default timing constants, shared with
//    the status/debug register block.
//  Sub-module atomik_sync2: generic 2-flop synchronizer for pll_lock, reused elsewhere.
// TESTING  (bench params: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
//  1 Lock 3 cycles after pll_reset falls, held -> pll_reset high exactly 4 cycles; ready=1, rst_out=0 after
//    2 (sync) + 8 stable cycles; retry_cnt=0.
//  2 Lock never asserts -> retry_cnt 1, 2, then fault=1 after 3rd timeout; pll_reset stays 1; restart clears fault.
//  3 Lock glitches low 1 cycle at stable-count 5 -> back to WAIT_LOCK, retry_cnt unchanged, RUN reached on re-lock.
//  4 Lock drop in RUN -> ready=0/rst_out=1 within 3 cycles, PLL_RST entered, lock_loss_count=1 (STATS_EN) / 0.
//  5 restart same cycle as timeout with retry_cnt=2 -> PLL_RST, not FAULT; retry_cnt=0.
//  6 reset in STABLE and in RUN -> all outputs return to reset values next cycle; 256 lock losses saturate at 255.

Source files
------------

// File: rtl/atomik_pll_supervisor_pkg.sv
// Shared definitions for the rPLL supervisor and the status/debug register
// block that decodes its state code.
//   pll_state_e          : state encoding (ST_PLL_RST..ST_FAULT); codes 5-7 are unused
//   DEF_*                : default timing constants for a 27 MHz reference clock
//   max3                 : helper used to size the shared cycle counter
package atomik_pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 27;     // 1 us
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 27000;  // 1 ms
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 2048;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/atomik_pll_supervisor_if.sv
// Control/status bundle between the PLL supervisor and its surroundings
// (rPLL wrapper, reset synchronizers, debug registers).
//   restart          : 1-cycle strobe, abort and start a fresh sequence
//   pll_lock         : raw rPLL lock, asynchronous to clkin
//   pll_reset        : to rPLL RESET
//   rst_out          : design reset request, high until lock is qualified
//   ready / fault    : high only in RUN / FAULT
//   state_o          : current state code
//   retry_cnt        : failed attempts in the current sequence
//   lock_loss_count  : saturating count of lock losses seen in RUN
// Handshake: there is no valid/ready pair on this bundle. restart is a
// single-cycle strobe acted on the cycle it is sampled high; every other
// signal is a level. master = supervisor side, slave = the other side.
interface atomik_pll_supervisor_if;
  logic       restart;
  logic       pll_lock;
  logic       pll_reset;
  logic       rst_out;
  logic       ready;
  logic       fault;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_count;

  modport master (
    input  restart, pll_lock,
    output pll_reset, rst_out, ready, fault, state_o, retry_cnt, lock_loss_count
  );

  modport slave (
    output restart, pll_lock,
    input  pll_reset, rst_out, ready, fault, state_o, retry_cnt, lock_loss_count
  );
endinterface

// File: rtl/atomik_sync2.sv
// Generic 2-flop synchronizer for a single level signal.
//   clk   : destination clock
//   rst   : synchronous active-high reset, forces both flops to RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, 2 cycles of latency
module atomik_sync2 #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];
endmodule

// File: rtl/atomik_pll_supervisor.sv
// rPLL start-up supervisor on the 27 MHz board clock. Pulses the PLL reset,
// waits for lock with timeout and retry, qualifies lock stability, then drops
// the design reset request. Lock loss in RUN re-sequences; exhausting the
// retries latches FAULT until reset or restart.
// Ports:
//   clkin  : 27 MHz reference, only clock of this block
//   reset  : synchronous active-high; beats restart, restart beats all else
//   bus    : atomik_pll_supervisor_if.master (see interface header)
// Optional feature: define ATOMIK_PLL_SUP_STATS_EN to build the saturating
// lock-loss counter (cleared only by reset). Without it lock_loss_count is 0.
module atomik_pll_supervisor
  import atomik_pll_supervisor_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic clkin,
  input  logic reset,
  atomik_pll_supervisor_if.master bus
);

  localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts: each window ends on the cycle the counter reads N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRIES);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             lock_s;
  logic             pll_reset_q, rst_out_q, ready_q, fault_q;

  atomik_sync2 #(.RESET_VAL(1'b0)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (bus.pll_lock),
    .q   (lock_s)
  );

  // Next-state logic. The counter is shared by all timed windows and is
  // cleared on every transition, so it never needs to wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (bus.restart) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_LAST) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_PLL_RST;
              retry_d = retry_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STABLE: begin
          // A drop on the completing cycle is checked first and wins.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          // ST_PLL_RST, and the unused codes 5-7 which behave the same way.
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  // State register. Outputs are registered from the next state so that they
  // line up exactly with state_o.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      rst_out_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
      rst_out_q   <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.rst_out   = rst_out_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.state_o   = state_q;
  assign bus.retry_cnt = retry_q;

`ifdef ATOMIK_PLL_SUP_STATS_EN
  // Counts RUN -> PLL_RST lock losses; a simultaneous restart takes priority
  // and is not counted. Restart does not clear the count.
  logic [7:0] loss_q;

  always_ff @(posedge clkin) begin
    if (reset) begin
      loss_q <= 8'd0;
    end else if (!bus.restart && (state_q == ST_RUN) && !lock_s && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.lock_loss_count = loss_q;
`else
  assign bus.lock_loss_count = 8'd0;
`endif

endmodule
